// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin burst arbiter for a FIFO push port
// Optional per-requester accepted-push counters: define FIFO_PUSH_ARBITER_STATS_EN.
module fifo_push_arbiter #(
   parameter int width     = 4,
   parameter int n_req     = 4,
   parameter int max_burst = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [n_req-1:0]         req,
   input  logic [n_req*width-1:0]   req_data,
   output logic [n_req-1:0]         gnt,
   input  logic                     fifo_full,
   output logic                     fifo_push,
   output logic [width-1:0]         fifo_write_data,
`ifdef FIFO_PUSH_ARBITER_STATS_EN
   output logic [n_req*16-1:0]      grant_cnt,
   input  logic                     stats_clear,
`endif
   output logic [$clog2(n_req)-1:0] owner
);

   localparam int OW = $clog2(n_req);

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [3:0]      burst_cnt_q, burst_cnt_d;
   logic [OW-1:0]   win, idx, grant_idx;
   logic            found, do_grant;

   // Decide who owns the push port this cycle and what the burst state becomes
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      win         = owner_q;
      idx         = owner_q;
      found       = 1'b0;
      do_grant    = 1'b0;
      grant_idx   = owner_q;
      // Rotating priority: the requester just after the last owner comes first
      for (int k = 1; k <= n_req; k++) begin
         idx = OW'((int'(owner_q) + k) % n_req);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      // A full FIFO freezes everything; gating on rst_n keeps outputs quiet in reset
      if (rst_n && !fifo_full) begin
         if (state_q == BURST && req[owner_q] && burst_cnt_q < 4'(max_burst)) begin
            do_grant    = 1'b1;
            grant_idx   = owner_q;
            burst_cnt_d = burst_cnt_q + 4'd1;
            state_d     = (burst_cnt_q + 4'd1 >= 4'(max_burst)) ? IDLE : BURST;
         end else if (found) begin
            // Owner dropped its request or no burst in progress: hand over at once
            do_grant    = 1'b1;
            grant_idx   = win;
            owner_d     = win;
            burst_cnt_d = 4'd1;
            state_d     = (max_burst > 1) ? BURST : IDLE;
         end else begin
            state_d = IDLE;
         end
      end
   end

   // One-hot grant and steering of the granted producer's data
   always_comb begin
      gnt             = '0;
      fifo_write_data = '0;
      for (int i = 0; i < n_req; i++) begin
         if (do_grant && grant_idx == OW'(i)) begin
            gnt[i]          = 1'b1;
            fifo_write_data = req_data[i*width +: width];
         end
      end
   end

   assign fifo_push = |gnt;
   assign owner     = owner_q;

   // Burst state machine; owner resets to the last index so requester 0 wins first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OW'(n_req - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
   logic [n_req*16-1:0] grant_cnt_q, grant_cnt_d;

   // Saturating per-requester push counters; clear wins over increment
   always_comb begin
      grant_cnt_d = grant_cnt_q;
      for (int i = 0; i < n_req; i++) begin
         if (stats_clear) begin
            grant_cnt_d[i*16 +: 16] = 16'd0;
         end else if (gnt[i] && grant_cnt_q[i*16 +: 16] != 16'hFFFF) begin
            grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
         end
      end
   end

   // Counter storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
      end
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - scoreboard bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

   localparam int W = 4;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req, req1, gnt, gnt1;
   logic [N*W-1:0] req_data, req_data1;
   logic           fifo_full;
   logic           push, push1;
   logic [W-1:0]   wdata, wdata1;
   logic [1:0]     owner, owner1;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
   logic           stats_clear;
   logic [N*16-1:0] grant_cnt, grant_cnt1;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int step_no  = 0;

   typedef struct packed {
      logic [N-1:0] gnt;
      logic         push;
      logic [W-1:0] data;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   always #5 clk = ~clk;

   fifo_push_arbiter #(.width(W), .n_req(N), .max_burst(2)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req),
      .req_data        (req_data),
      .gnt             (gnt),
      .fifo_full       (fifo_full),
      .fifo_push       (push),
      .fifo_write_data (wdata),
`ifdef FIFO_PUSH_ARBITER_STATS_EN
      .grant_cnt       (grant_cnt),
      .stats_clear     (stats_clear),
`endif
      .owner           (owner)
   );

   fifo_push_arbiter #(.width(W), .n_req(N), .max_burst(1)) u_dut_rr (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req1),
      .req_data        (req_data1),
      .gnt             (gnt1),
      .fifo_full       (fifo_full),
      .fifo_push       (push1),
      .fifo_write_data (wdata1),
`ifdef FIFO_PUSH_ARBITER_STATS_EN
      .grant_cnt       (grant_cnt1),
      .stats_clear     (stats_clear),
`endif
      .owner           (owner1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input int e, input logic [N*W-1:0] d);
      exp_t x;
      x = '0;
      if (e >= 0) begin
         x.gnt  = N'(1) << e;
         x.push = 1'b1;
         x.data = W'(d >> (e * W));
      end
      return x;
   endfunction

   task automatic compare(input string tag, input logic [N-1:0] g, input logic p,
                          input logic [W-1:0] d, input int which);
      exp_t x;
      if (which == 0) begin
         if (sb0.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
         end
         x = sb0.pop_front();
      end else begin
         if (sb1.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
         end
         x = sb1.pop_front();
      end
      check({tag, "_gnt"},  32'(g), 32'(x.gnt));
      check({tag, "_push"}, 32'(p), 32'(x.push));
      check({tag, "_data"}, 32'(d), 32'(x.data));
   endtask

   // Called at posedge+1: drive one cycle, expect granted index e (dut) / e1 (round-robin dut), -1 = none
   task automatic step(input logic [N-1:0] r, input logic [N-1:0] r1, input logic f,
                       input int e, input int e1);
      req       = r;
      req1      = r1;
      fifo_full = f;
      req_data  = 16'($urandom);
      req_data1 = 16'($urandom);
      sb0.push_back(mk(e, req_data));
      sb1.push_back(mk(e1, req_data1));
      @(negedge clk);
      compare($sformatf("s%0d_mb2", step_no), gnt, push, wdata, 0);
      compare($sformatf("s%0d_mb1", step_no), gnt1, push1, wdata1, 1);
      step_no++;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req       = '1;
      req1      = '1;
      fifo_full = 1'b0;
      #2;
      check("rst_gnt",   32'(gnt),   32'd0);
      check("rst_push",  32'(push),  32'd0);
      check("rst_data",  32'(wdata), 32'd0);
      check("rst_owner", 32'(owner), 32'd3);
      check("rst_owner_rr", 32'(owner1), 32'd3);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int t1[10];
      int t2[8];
      logic [N-1:0] t2r[8];
      logic         t2f[8];
      req = '0; req1 = '0; req_data = '0; req_data1 = '0; fifo_full = 1'b0;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
      stats_clear = 1'b0;
`endif
      @(posedge clk);
      #1;
      apply_reset();

      // Burst of two per owner with everybody requesting
      t1 = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      foreach (t1[i]) step(4'b1111, 4'b0000, 1'b0, t1[i], -1);
      check("owner_after_rr", 32'(owner), 32'd0);

      // Full freezes a burst mid-way; requester 1 resumes its second push
      t2  = '{1, -1, -1, -1, 1, 2, 2, 3};
      t2f = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      t2r = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
      foreach (t2[i]) step(t2r[i], 4'b0000, t2f[i], t2[i], -1);
      check("owner_after_full", 32'(owner), 32'd3);

      // No request: nothing granted, owner held
      step(4'b0000, 4'b0000, 1'b0, -1, -1);
      check("owner_idle_hold", 32'(owner), 32'd3);

      // Requester 0 drops after one push; requester 1 takes over the next cycle
      apply_reset();
      step(4'b0011, 4'b0000, 1'b0, 0, -1);
      step(4'b0010, 4'b0000, 1'b0, 1, -1);
      step(4'b0011, 4'b0000, 1'b0, 1, -1);
      step(4'b0011, 4'b0000, 1'b0, 0, -1);

      // Asynchronous reset in the middle of requester 2's burst
      apply_reset();
      step(4'b1111, 4'b0000, 1'b0, 0, -1);
      step(4'b1111, 4'b0000, 1'b0, 0, -1);
      step(4'b1111, 4'b0000, 1'b0, 1, -1);
      step(4'b1111, 4'b0000, 1'b0, 1, -1);
      step(4'b1111, 4'b0000, 1'b0, 2, -1);
      check("mid_owner_pre", 32'(owner), 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_gnt",   32'(gnt),   32'd0);
      check("mid_rst_push",  32'(push),  32'd0);
      check("mid_rst_data",  32'(wdata), 32'd0);
      check("mid_rst_owner", 32'(owner), 32'd3);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(4'b0100, 4'b0000, 1'b0, 2, -1);
      check("post_rst_owner", 32'(owner), 32'd2);

      // max_burst of one: plain alternation between requesters 1 and 3
      step(4'b0000, 4'b1010, 1'b0, -1, 1);
      step(4'b0000, 4'b1010, 1'b0, -1, 3);
      step(4'b0000, 4'b1010, 1'b0, -1, 1);
      step(4'b0000, 4'b1010, 1'b0, -1, 3);
      check("owner_rr_mb1", 32'(owner1), 32'd3);

`ifdef FIFO_PUSH_ARBITER_STATS_EN
      // Counter saturation and clear-over-increment
      apply_reset();
      req = 4'b0001; req1 = 4'b0000; fifo_full = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      check("cnt_sat", 32'(grant_cnt[15:0]), 32'hFFFF);
      check("cnt_other", 32'(grant_cnt[31:16]), 32'd0);
      stats_clear = 1'b1;
      @(negedge clk);
      check("clr_push_same_cycle", 32'(gnt), 32'd1);
      @(posedge clk);
      #1;
      stats_clear = 1'b0;
      req = 4'b0000;
      check("cnt_cleared", 32'(grant_cnt[15:0]), 32'd0);
`endif

      check("sb0_drained", 32'(sb0.size()), 32'd0);
      check("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
